// File: rtl/sprite_blit_engine_if.sv
// Draw-request and memory-port bundle between the draw scheduler, the sprite/frame RAMs
// and the sprite blit engine.
interface sprite_blit_engine_if;
  logic        start;
  logic [9:0]  pos_x;
  logic [8:0]  pos_y;
  logic        size_sel;
  logic [19:0] sprite_addr;
  logic [15:0] sprite_data;
  logic [18:0] frame_rd_addr;
  logic [15:0] frame_rd_data;
  logic [18:0] frame_wr_addr;
  logic [15:0] frame_wr_data;
  logic        frame_we;
  logic        busy;
  logic        done;

  modport slave (
    input  start, pos_x, pos_y, size_sel, sprite_data, frame_rd_data,
    output sprite_addr, frame_rd_addr, frame_wr_addr, frame_wr_data, frame_we, busy, done
  );

  modport master (
    output start, pos_x, pos_y, size_sel, sprite_data, frame_rd_data,
    input  sprite_addr, frame_rd_addr, frame_wr_addr, frame_wr_data, frame_we, busy, done
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Copies a 32x32 or 4x4 sprite into frameRAM with per-pixel transparency, using one
// read-modify-write (READ cycle + WRITE cycle) per 16-bit frame word, with edge clipping.
module sprite_blit_engine #(
  parameter int          FRAME_W_WORDS = 320,
  parameter int          FRAME_H       = 480,
  parameter logic [7:0]  TRANSPARENT   = 8'h00
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sprite_blit_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [8:0]  base_x_r, base_y_r;
  logic        size_r;
  logic [4:0]  row_r, next_row_s, last_row_s;
  logic [3:0]  col_r, next_col_s, last_col_s;
  logic        last_word_s;
  logic [18:0] x_s, y_s;
  logic        clip_s;
  logic [19:0] sprite_addr_r;
  logic [18:0] frame_rd_addr_r, frame_wr_addr_r;
  logic        frame_we_r, busy_r, done_r;
  logic [15:0] merged_s;
  logic        unused_pos_x_lsb_s;

  function automatic logic [18:0] frame_addr(input logic [8:0] bx, input logic [8:0] by,
                                             input logic [4:0] row, input logic [3:0] col);
    frame_addr = (19'(by) + 19'(row)) * 19'(FRAME_W_WORDS) + 19'(bx) + 19'(col);
  endfunction

  function automatic logic [19:0] sprite_word(input logic sz, input logic [4:0] row,
                                              input logic [3:0] col);
    sprite_word = sz ? {14'd0, row, col[0]} : {11'd0, row, col};
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] spr, input logic [7:0] frm);
    merge_byte = (spr != TRANSPARENT) ? spr : frm;
  endfunction

  // Sprite geometry, iteration step and clip test for the current word
  always_comb begin
    last_col_s  = size_r ? 4'd1 : 4'd15;
    last_row_s  = size_r ? 5'd3 : 5'd31;
    last_word_s = (col_r == last_col_s) && (row_r == last_row_s);
    if (col_r == last_col_s) begin
      next_col_s = 4'd0;
      next_row_s = row_r + 5'd1;
    end else begin
      next_col_s = col_r + 4'd1;
      next_row_s = row_r;
    end
    x_s    = 19'(base_x_r) + 19'(col_r);
    y_s    = 19'(base_y_r) + 19'(row_r);
    clip_s = (x_s >= 19'(FRAME_W_WORDS)) || (y_s >= 19'(FRAME_H));
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:  state_next_s = WRITE;
      WRITE: begin
        if (last_word_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = READ;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they line up with state_r
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
    end
  end

  // Datapath: addresses for the next READ are prepared on the edge entering READ
  always_ff @(posedge Clk) begin
    if (Reset) begin
      base_x_r        <= 9'd0;
      base_y_r        <= 9'd0;
      size_r          <= 1'b0;
      row_r           <= 5'd0;
      col_r           <= 4'd0;
      sprite_addr_r   <= 20'd0;
      frame_rd_addr_r <= 19'd0;
      frame_wr_addr_r <= 19'd0;
      frame_we_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_we_r <= 1'b0;
          if (bus.start) begin
            base_x_r        <= bus.pos_x[9:1];
            base_y_r        <= bus.pos_y;
            size_r          <= bus.size_sel;
            row_r           <= 5'd0;
            col_r           <= 4'd0;
            sprite_addr_r   <= 20'd0;
            frame_rd_addr_r <= frame_addr(bus.pos_x[9:1], bus.pos_y, 5'd0, 4'd0);
          end
        end
        READ: begin
          frame_wr_addr_r <= frame_rd_addr_r;
          frame_we_r      <= !clip_s;
        end
        WRITE: begin
          frame_we_r <= 1'b0;
          if (!last_word_s) begin
            row_r           <= next_row_s;
            col_r           <= next_col_s;
            sprite_addr_r   <= sprite_word(size_r, next_row_s, next_col_s);
            frame_rd_addr_r <= frame_addr(base_x_r, base_y_r, next_row_s, next_col_s);
          end
        end
        DONE:    frame_we_r <= 1'b0;
        default: frame_we_r <= 1'b0;
      endcase
    end
  end

  // Memory read data arrives during WRITE, so the merge must be combinational
  always_comb begin
    merged_s = 16'd0;
    if (state_r == WRITE) begin
      merged_s = {merge_byte(bus.sprite_data[15:8], bus.frame_rd_data[15:8]),
                  merge_byte(bus.sprite_data[7:0],  bus.frame_rd_data[7:0])};
    end else begin
      merged_s = 16'd0;
    end
  end

  assign unused_pos_x_lsb_s = bus.pos_x[0];

  assign bus.sprite_addr   = sprite_addr_r;
  assign bus.frame_rd_addr = frame_rd_addr_r;
  assign bus.frame_wr_addr = frame_wr_addr_r;
  assign bus.frame_wr_data = merged_s;
  assign bus.frame_we      = frame_we_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine: behavioural sprite/frame RAMs, a vector table of
// blits with hand-computed results, plus start-ignore and mid-blit reset sequences.
module tb_sprite_blit_engine;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  sprite_blit_engine_if bus();

  sprite_blit_engine dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  logic [15:0] fmem [0:524287];
  logic [18:0] wlog [0:4095];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  logic        prev_we = 1'b0;
  logic        bad_addr = 1'b0;
  logic        bad_we = 1'b0;
  logic        pre_we = 1'b0;
  logic [18:0] pre_addr = 19'd0;
  logic [15:0] pre_data = 16'd0;
  logic        spr_mode = 1'b0;
  logic [15:0] spr_fill = 16'd0;

  int checks = 0;
  int failures = 0;

  // RAM models: one-cycle read latency on both memories
  always @(posedge Clk) begin
    if (pre_we) fmem[pre_addr] <= pre_data;
    else if (bus.frame_we) fmem[bus.frame_wr_addr] <= bus.frame_wr_data;
    bus.frame_rd_data <= fmem[bus.frame_rd_addr];
    bus.sprite_data   <= spr_mode ? {4'h8, bus.sprite_addr[11:0]} : spr_fill;
  end

  // Write/done monitor
  always @(posedge Clk) begin
    if (bus.frame_we) begin
      wlog[wr_cnt % 4096] <= bus.frame_wr_addr;
      wr_cnt <= wr_cnt + 1;
      if (bus.frame_wr_addr >= 19'd153600) bad_addr <= 1'b1;
      if (prev_we) bad_we <= 1'b1;
    end
    prev_we <= bus.frame_we;
    if (bus.done) done_cnt <= done_cnt + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [18:0] a, input logic [15:0] d);
    @(negedge Clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  task automatic run_blit(input logic [9:0] px, input logic [8:0] py, input logic sz,
                          output int lat, output int n, output logic [18:0] first,
                          output logic [18:0] last);
    int base, t0;
    base = wr_cnt;
    @(negedge Clk);
    bus.start = 1'b1; bus.pos_x = px; bus.pos_y = py; bus.size_sel = sz;
    t0 = cyc;
    @(negedge Clk);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 1200; i++) begin
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
    @(negedge Clk);
    n = wr_cnt - base;
    first = (n > 0) ? wlog[base % 4096] : 19'h7FFFF;
    last  = (n > 0) ? wlog[(wr_cnt - 1) % 4096] : 19'h7FFFF;
  endtask

  typedef struct {
    logic [9:0]  px;
    logic [8:0]  py;
    logic        sz;
    logic        mode;
    logic [15:0] fill;
    logic [18:0] pre_addr;
    logic [15:0] pre_data;
    int          n;
    int          lat;
    logic [18:0] first;
    logic [18:0] last;
    logic [15:0] chk_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, n, base, dc, t0;
    logic [18:0] first, last;

    vecs[0] = '{10'd0,   9'd0,   1'b1, 1'b0, 16'h1111, 19'd961,    16'hFFFF, 8,  17,   19'd0,      19'd961,    16'h1111};
    vecs[1] = '{10'd100, 9'd10,  1'b1, 1'b0, 16'h0022, 19'd3250,   16'hAB00, 8,  17,   19'd3250,   19'd4211,   16'hAB22};
    vecs[2] = '{10'd101, 9'd10,  1'b1, 1'b0, 16'h0022, 19'd3250,   16'hAB00, 8,  17,   19'd3250,   19'd4211,   16'hAB22};
    vecs[3] = '{10'd624, 9'd470, 1'b0, 1'b1, 16'h0000, 19'd153599, 16'h00CD, 80, 1025, 19'd150712, 19'd153599, 16'h8097};
    vecs[4] = '{10'd638, 9'd100, 1'b1, 1'b0, 16'h5555, 19'd32320,  16'h0777, 4,  17,   19'd32319,  19'd33279,  16'h0777};
    vecs[5] = '{10'd0,   9'd478, 1'b1, 1'b0, 16'h0000, 19'd153281, 16'h1234, 4,  17,   19'd152960, 19'd153281, 16'h1234};

    bus.start = 1'b0; bus.pos_x = 10'd0; bus.pos_y = 9'd0; bus.size_sel = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_we", 32'(bus.frame_we), 32'd0);
    chk("rst_spr_addr", 32'(bus.sprite_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.frame_rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(bus.frame_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.frame_wr_data), 32'd0);
    Reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      spr_mode = vecs[v].mode;
      spr_fill = vecs[v].fill;
      preload(vecs[v].pre_addr, vecs[v].pre_data);
      run_blit(vecs[v].px, vecs[v].py, vecs[v].sz, lat, n, first, last);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_writes", v), 32'(n), 32'(vecs[v].n));
      chk($sformatf("v%0d_first", v), 32'(first), 32'(vecs[v].first));
      chk($sformatf("v%0d_last", v), 32'(last), 32'(vecs[v].last));
      chk($sformatf("v%0d_data", v), 32'(fmem[vecs[v].pre_addr]), 32'(vecs[v].chk_data));
      chk($sformatf("v%0d_idle", v), 32'(bus.busy), 32'd0);
    end

    // Starts during the blit and in the done cycle are dropped
    spr_mode = 1'b0; spr_fill = 16'h1111;
    base = wr_cnt; dc = done_cnt; lat = -1;
    @(negedge Clk);
    bus.start = 1'b1; bus.pos_x = 10'd0; bus.pos_y = 9'd200; bus.size_sel = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      bus.start = (cyc == t0 + 5) || (cyc == t0 + 9);
      bus.pos_x = 10'd2; bus.pos_y = 9'd2;
      if (bus.done) begin
        bus.start = 1'b1;
        lat = cyc - t0;
        break;
      end
    end
    @(negedge Clk);
    bus.start = 1'b0;
    chk("ign_idle1", 32'(bus.busy), 32'd0);
    @(negedge Clk);
    chk("ign_idle2", 32'(bus.busy), 32'd0);
    @(negedge Clk);
    chk("ign_latency", 32'(lat), 32'd17);
    chk("ign_writes", 32'(wr_cnt - base), 32'd8);
    chk("ign_dones", 32'(done_cnt - dc), 32'd1);
    chk("ign_first", 32'(wlog[base % 4096]), 32'd64000);

    // Reset during the WRITE of word 200 of a 32x32 blit
    spr_mode = 1'b1;
    base = wr_cnt;
    @(negedge Clk);
    bus.start = 1'b1; bus.pos_x = 10'd0; bus.pos_y = 9'd0; bus.size_sel = 1'b0;
    @(negedge Clk);
    bus.start = 1'b0;
    for (int i = 0; i < 401; i++) @(negedge Clk);
    chk("rst200_we", 32'(bus.frame_we), 32'd1);
    chk("rst200_addr", 32'(bus.frame_wr_addr), 32'd3848);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst200_we_off", 32'(bus.frame_we), 32'd0);
    chk("rst200_busy", 32'(bus.busy), 32'd0);
    chk("rst200_done", 32'(bus.done), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge Clk);
    chk("rst200_writes", 32'(wr_cnt - base), 32'd201);
    chk("rst200_idle", 32'(bus.busy), 32'd0);
    run_blit(10'd0, 9'd0, 1'b0, lat, n, first, last);
    chk("after_rst_latency", 32'(lat), 32'd1025);
    chk("after_rst_writes", 32'(n), 32'd512);
    chk("after_rst_first", 32'(first), 32'd0);
    chk("after_rst_last", 32'(last), 32'd9935);
    chk("after_rst_data", 32'(fmem[9935]), 32'h81FF);

    chk("addr_range", 32'(bad_addr), 32'd0);
    chk("we_spacing", 32'(bad_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_blit_engine.md
# sprite_blit_engine

Copies one sprite (a 32x32 bike or a 4x4 trail/corner tile) from a sprite RAM into frameRAM at a given pixel position. Both memories store two 8-bit palette pixels per 16-bit word, and index 0x00 is transparent. The engine does a read-modify-write on every frameRAM word it touches, so transparent sprite pixels leave the background intact. It sits directly upstream of frameRAM, between the game-logic draw scheduler and the frame buffer; an external mux selects which sprite RAM feeds `sprite_data`.

## Interface
Parameters:
- `FRAME_W_WORDS`, 320: frameRAM words per scanline (640 px / 2).
- `FRAME_H`, 480: scanlines.
- `TRANSPARENT`, 8'h00: palette index that is never written.

Ports:
- `Clk`, in, 1: single clock. Everything is rising-edge.
- `Reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request pulse. Ignored while `busy`=1.
- `pos_x`, in, 10: sprite left edge in pixels. Bit 0 is ignored (even alignment).
- `pos_y`, in, 9: sprite top row.
- `size_sel`, in, 1: 0 = 32x32 (16 words/row, 32 rows); 1 = 4x4 (2 words/row, 4 rows).
- `sprite_addr`, out, 20: word address into the selected sprite RAM.
- `sprite_data`, in, 16: sprite RAM `data_Out`, valid one cycle after `sprite_addr`.
- `frame_rd_addr`, out, 19: frameRAM `read_address`.
- `frame_rd_data`, in, 16: frameRAM `data_Out`, valid one cycle after `frame_rd_addr`.
- `frame_wr_addr`, out, 19: frameRAM `write_address`.
- `frame_wr_data`, out, 16: frameRAM `data_In`.
- `frame_we`, out, 1: frameRAM `we`.
- `busy`, out, 1: high while a blit is in progress. The top level gives the engine the frameRAM read port while `busy`=1.
- `done`, out, 1: one-cycle pulse when the blit completes.

## Operation
- Pixel packing: bits [15:8] hold the left (even-x) pixel and bits [7:0] hold the right (odd-x) pixel, in both memories.
- On `start` in IDLE, latch `pos_x[9:1]`, `pos_y` and `size_sel`, and clear `row`/`col`.
- State machine: IDLE -> READ on `start`; READ -> WRITE unconditionally; from WRITE:
  - -> READ if words remain;
  - -> DONE after the last word;
  - DONE -> IDLE unconditionally.
- READ drives the addresses:
  - `sprite_addr` = row*WPR + col, where WPR is 16 or 2;
  - `frame_rd_addr` = (pos_y+row)*FRAME_W_WORDS + (pos_x[9:1]+col).
  - Compute with 19-bit unsigned arithmetic.
- WRITE merges the two returned words:
  - each output byte = sprite byte if it is != TRANSPARENT, else the frame byte;
  - drive `frame_wr_addr` with the same address used in READ, `frame_wr_data` with the merged word, and `frame_we`=1.
- Clipping: if pos_x[9:1]+col >= FRAME_W_WORDS or pos_y+row >= FRAME_H, the word is skipped, `frame_we`=0 that WRITE cycle, and the state still advances. No horizontal wrap into the next scanline.
- Iteration order: col increments first; at col = WPR-1, col returns to 0 and row increments. The last word is row = rows-1, col = WPR-1.
- `busy`=1 in READ, WRITE and DONE. `done`=1 in DONE only.
- A `start` arriving while busy is dropped, with no queueing.

## Timing
- Reset values (at the first edge with `Reset`=1, from any state):
  - `busy`=0, `done`=0, `frame_we`=0;
  - all address and data outputs = 0;
  - state = IDLE.
- Reset mid-blit aborts with no further writes. A write in flight is suppressed from the next cycle onward.
- Cycle t holds `start`. READ of word 0 is at t+1, with its WRITE at t+2. Word n has its READ at t+1+2n and its WRITE at t+2+2n.
- Latency from `start` to `done`:
  - 32x32 sprite, 512 words: WRITE of the last word at t+1024, `done` at t+1025, `busy` low and IDLE at t+1026;
  - 4x4 sprite, 8 words: `done` at t+17.
- A `start` in the same cycle as `done` is ignored. A new `start` is accepted from the IDLE cycle after `done`.
- At most one frameRAM write per 2 cycles. `frame_we` never asserts in READ, IDLE or DONE.

## Test plan
- 4x4 opaque tile of all 0x1111 at (0,0) -> 8 writes at addresses 0,1,320,321,640,641,960,961, each with data 0x1111; `done` at t+17.
- 4x4 tile word 0x0022 over frame word 0xAB00 at (100,10) -> address 3250 written with 0xAB22 (left pixel kept, right replaced).
- 32x32 at (624,470) -> only cols 0-7 and rows 0-9 are written (80 writes). No address above 153599. `done` at t+1025.
- `start` pulses during a blit and in the `done` cycle -> ignored. Exactly one `done` per accepted start, and write count unchanged.
- `Reset` asserted at word 200 of a 32x32 blit -> `frame_we`=0 from the next cycle, `busy`=0, IDLE. A following `start` blits correctly from word 0.
- Odd `pos_x`=101 -> behaves identically to `pos_x`=100.
